aes_encipher_block: RTL and testbench
=====================================

Name: aes_encipher_block

Overview:
Iterative AES encipher datapath. It is the forward counterpart to the decipher round engine and sits beside it under the AES core top level. It sequences the initial AddRoundKey, the main rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round (no MixColumns) for 128- and 256-bit keys. Round keys come from the shared key memory, indexed by the exported round number.

Parameters:
None. Round counts are fixed constants: AES128_ROUNDS = 10, AES256_ROUNDS = 14.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
next  in  1  start request; sampled only in IDLE
keylen  in  1  0 = AES-128, 1 = AES-256; sampled with next
round  out  4  current round index, used by key memory to select round_key
round_key  in  128  key for the current round; combinational from round
block  in  128  plaintext; must be stable from next until the INIT cycle completes
new_block  out  128  state register {w0,w1,w2,w3}, w0 = bits 127:96; ciphertext when ready rises
ready  out  1  1 = idle with result valid; 0 = busy

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: new_block = 0, round = 0, ready = 1, FSM = IDLE, sbox word counter = 0, latched round limit = 10.
- Registers: four 32-bit state words w0..w3, each with its own write enable.
- Counters:
  - 2-bit sbox word counter.
  - 4-bit round counter; counts up and never wraps within an operation.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - On next=1: round <= 0, latch round limit (10 or 14 from keylen), ready <= 0, go to INIT.
  - next=0: hold all state.
- INIT: state <= block ^ round_key (key 0); round <= 1; word counter <= 0; go to SBOX.
- SBOX:
  - One word per cycle through a single forward S-box, w0 first, then w1, w2, w3.
  - Word counter increments each cycle.
  - At counter = 3, go to MAIN.
- MAIN with round < limit:
  - state <= AddRoundKey(MixColumns(ShiftRows(state)), round_key).
  - round <= round + 1; word counter <= 0; go to SBOX.
- MAIN with round == limit (final round):
  - state <= AddRoundKey(ShiftRows(state), round_key).
  - ready <= 1; go to IDLE.
- ShiftRows: row r (byte r of each word, byte 0 = MSB) rotates left by r columns. Output word c byte r = input word (c+r) mod 4 byte r.
- MixColumns per word: GF(2^8) with polynomial 0x11b, matrix rows {2,3,1,1} rotated.
- Latency: count the edge that samples next as edge 1. ready is high after edge 52 for AES-128 and after edge 72 for AES-256. new_block is valid whenever ready=1.
- next while busy: ignored; the operation is not restarted.
- next held high: a new operation starts on the edge after ready rises (back-to-back operation allowed).
- keylen or block changes while busy: no effect on the operation in flight (keylen is latched; block is read only in INIT).
- Reset mid-operation: immediately returns to reset values; partial results are discarded.
- round is undefined to consumers while ready=1, but holds its last value (limit).

Optional Feature:
AES_ENC_FAST_SBOX_EN
- Defined:
  - Four S-box instances substitute all words in one SBOX cycle; SBOX lasts one cycle.
  - Each round takes 2 cycles. Latency: AES-128 = 22 edges, AES-256 = 30 edges.
  - The word counter is removed.
- Undefined: the single-S-box, 4-cycle SBOX described above.
- Ports and results are identical in both builds.

Decomposition:
- Shared include aes_defines (package-equivalent) holds:
  - AES_128_BIT_KEY and AES_256_BIT_KEY;
  - AES128_ROUNDS and AES256_ROUNDS;
  - FSM state encodings (CTRL_IDLE/INIT/SBOX/MAIN);
  - update-type codes.
  The decipher block shares this include.
- GF helper functions (gm2, gm3) and shiftrows/mixcolumns stay local functions in this module.
- Sub-module aes_sbox: pure combinational 32-bit forward S-box (four byte lookups), instantiated once, or four times under the macro.

Test Plan:
- FIPS-197 C.1, AES-128: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff. Expect new_block = 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises after edge 52 (22 under the macro).
- FIPS-197 C.3, AES-256: key 000102…1e1f, same pt. Expect 8ea2b7ca516745bfeafc49904b496089; ready rises after edge 72 (30 under the macro); round sequence 0,1..14 observed.
- SP800-38A, AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a. Expect 3ad77bb40d7a3660a89ecaf32466ef97.
- Pulse next again mid-operation and toggle keylen and block while busy. Expect the result still equal to the original vector's ciphertext and latency unchanged.
- Assert reset_n low at round 5. Expect ready = 1, new_block = 0 and round = 0 immediately, without waiting for a clock edge. A following next runs C.1 correctly.
- Hold next high across two operations. Expect the second to start on the edge after ready rises, with both ciphertexts correct.

Source files
------------

// File: rtl/aes_encipher_block_pkg.sv
// -----------------------------------------------------------------------------
// aes_encipher_block_pkg
// Shared AES definitions used by the encipher and decipher round engines:
// key-length codes, round counts, control FSM encodings and the datapath
// update-type codes.
// -----------------------------------------------------------------------------
package aes_encipher_block_pkg;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam logic [3:0] AES128_ROUNDS = 4'd10;
   localparam logic [3:0] AES256_ROUNDS = 4'd14;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'd0,
      CTRL_INIT = 2'd1,
      CTRL_SBOX = 2'd2,
      CTRL_MAIN = 2'd3
   } ctrl_state_e;

   typedef enum logic [2:0] {
      NO_UPDATE    = 3'd0,
      INIT_UPDATE  = 3'd1,
      SBOX_UPDATE  = 3'd2,
      MAIN_UPDATE  = 3'd3,
      FINAL_UPDATE = 3'd4
   } update_e;

endpackage

// File: rtl/aes_encipher_block_if.sv
// -----------------------------------------------------------------------------
// aes_encipher_block_if
// Request/response bundle between the AES core top level (master) and the
// encipher round engine (slave).
//   next      start request, sampled in IDLE
//   keylen    0 = AES-128, 1 = AES-256, sampled with next
//   round     current round index (engine -> key memory)
//   round_key key for the current round (key memory -> engine)
//   block     plaintext
//   new_block state / ciphertext {w0,w1,w2,w3}, w0 = bits 127:96
//   ready     1 = idle with result valid
// -----------------------------------------------------------------------------
interface aes_encipher_block_if;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, round_key, block,
      input  round, new_block, ready
   );

   modport slave (
      input  next, keylen, round_key, block,
      output round, new_block, ready
   );
endinterface

// File: rtl/aes_encipher_block_sbox.sv
// -----------------------------------------------------------------------------
// aes_encipher_block_sbox
// Pure combinational 32-bit forward AES S-box: four independent byte lookups.
//   sbox_in   32-bit word to substitute
//   sbox_out  substituted word
// -----------------------------------------------------------------------------
module aes_encipher_block_sbox (
   input  logic [31:0] sbox_in,
   output logic [31:0] sbox_out
);

   // Entry 0 sits in the top byte of the vector.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   assign sbox_out = {sub_byte(sbox_in[31:24]), sub_byte(sbox_in[23:16]),
                      sub_byte(sbox_in[15:8]),  sub_byte(sbox_in[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// -----------------------------------------------------------------------------
// aes_encipher_block
// Iterative AES encipher datapath for 128- and 256-bit keys. Round keys come
// from the shared key memory, indexed by the exported round number.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      aes_encipher_block_if.slave (next, keylen, round, round_key,
//            block, new_block, ready)
// Build option:
//   AES_ENC_FAST_SBOX_EN  four S-boxes, SBOX phase takes one cycle
//                         (default: one S-box, one word per cycle)
//
// state      | meaning
// -----------+------------------------------------------------------------
// CTRL_IDLE  | result valid, waiting for next
// CTRL_INIT  | initial AddRoundKey with key 0
// CTRL_SBOX  | SubBytes on the state words
// CTRL_MAIN  | ShiftRows, MixColumns (skipped in last round), AddRoundKey
// -----------------------------------------------------------------------------
module aes_encipher_block
   import aes_encipher_block_pkg::*;
(
   input logic                 clk,
   input logic                 reset_n,
   aes_encipher_block_if.slave bus
);

   ctrl_state_e  state_q, state_d;
   update_e      upd;
   logic [3:0]   round_q, round_d;
   logic [3:0]   limit_q, limit_d;
   logic         ready_q, ready_d;
   logic [31:0]  w_q [4];
   logic [3:0]   w_we;
   logic [127:0] state_blk;
   logic [127:0] upd_blk;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = w;
      return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
              b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] s);
      return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
   endfunction

   // Output word c, byte r comes from input word (c+r) mod 4, byte r.
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      return {s[127:120], s[87:80],   s[47:40],   s[7:0],
              s[95:88],   s[55:48],   s[15:8],    s[103:96],
              s[63:56],   s[23:16],   s[111:104], s[71:64],
              s[31:24],   s[119:112], s[79:72],   s[39:32]};
   endfunction

   assign state_blk     = {w_q[0], w_q[1], w_q[2], w_q[3]};
   assign bus.new_block = state_blk;
   assign bus.round     = round_q;
   assign bus.ready     = ready_q;

`ifdef AES_ENC_FAST_SBOX_EN
   logic [31:0] sbox_out [4];
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_encipher_block_sbox u_sbox (.sbox_in(w_q[g]), .sbox_out(sbox_out[g]));
   end
`else
   logic [1:0]  word_ctr_q, word_ctr_d;
   logic [31:0] sbox_out;
   aes_encipher_block_sbox u_sbox (.sbox_in(w_q[word_ctr_q]), .sbox_out(sbox_out));
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= CTRL_IDLE;
         round_q    <= 4'd0;
         limit_q    <= AES128_ROUNDS;
         ready_q    <= 1'b1;
`ifndef AES_ENC_FAST_SBOX_EN
         word_ctr_q <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         limit_q    <= limit_d;
         ready_q    <= ready_d;
`ifndef AES_ENC_FAST_SBOX_EN
         word_ctr_q <= word_ctr_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      limit_d    = limit_q;
      ready_d    = ready_q;
      upd        = NO_UPDATE;
`ifndef AES_ENC_FAST_SBOX_EN
      word_ctr_d = word_ctr_q;
`endif
      case (state_q)
         CTRL_IDLE: begin
            if (bus.next) begin
               round_d = 4'd0;
               ready_d = 1'b0;
               state_d = CTRL_INIT;
               case (bus.keylen)
                  AES_128_BIT_KEY: limit_d = AES128_ROUNDS;
                  AES_256_BIT_KEY: limit_d = AES256_ROUNDS;
               endcase
            end
         end
         CTRL_INIT: begin
            upd     = INIT_UPDATE;
            round_d = 4'd1;
            state_d = CTRL_SBOX;
`ifndef AES_ENC_FAST_SBOX_EN
            word_ctr_d = 2'd0;
`endif
         end
         CTRL_SBOX: begin
            upd = SBOX_UPDATE;
`ifdef AES_ENC_FAST_SBOX_EN
            state_d = CTRL_MAIN;
`else
            word_ctr_d = word_ctr_q + 2'd1;
            if (word_ctr_q == 2'd3) state_d = CTRL_MAIN;
`endif
         end
         CTRL_MAIN: begin
            if (round_q < limit_q) begin
               upd     = MAIN_UPDATE;
               round_d = round_q + 4'd1;
               state_d = CTRL_SBOX;
`ifndef AES_ENC_FAST_SBOX_EN
               word_ctr_d = 2'd0;
`endif
            end else begin
               upd     = FINAL_UPDATE;
               ready_d = 1'b1;
               state_d = CTRL_IDLE;
            end
         end
         default: state_d = CTRL_IDLE;
      endcase
   end

   always_comb begin
      w_we    = 4'h0;
      upd_blk = state_blk;
      case (upd)
         INIT_UPDATE: begin
            upd_blk = bus.block ^ bus.round_key;
            w_we    = 4'hf;
         end
         SBOX_UPDATE: begin
`ifdef AES_ENC_FAST_SBOX_EN
            upd_blk = {sbox_out[0], sbox_out[1], sbox_out[2], sbox_out[3]};
            w_we    = 4'hf;
`else
            // Same substituted word offered to all lanes; only one lane loads.
            upd_blk          = {4{sbox_out}};
            w_we[word_ctr_q] = 1'b1;
`endif
         end
         MAIN_UPDATE: begin
            upd_blk = mixcolumns(shiftrows(state_blk)) ^ bus.round_key;
            w_we    = 4'hf;
         end
         FINAL_UPDATE: begin
            upd_blk = shiftrows(state_blk) ^ bus.round_key;
            w_we    = 4'hf;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (w_we[i]) w_q[i] <= upd_blk[127-32*i -: 32];
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
module tb_aes_encipher_block;

   logic clk;
   logic reset_n;

   aes_encipher_block_if aes_if();

   aes_encipher_block dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (aes_if)
   );

`ifdef AES_ENC_FAST_SBOX_EN
   localparam int LAT128 = 22;
   localparam int LAT256 = 30;
`else
   localparam int LAT128 = 52;
   localparam int LAT256 = 72;
`endif

   localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] SP_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] SP_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   typedef struct {
      logic [127:0] ct;
      int           start;
      int           lat;
      string        name;
   } exp_t;

   exp_t         sb_q[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   logic [7:0]   sb_tab [256];
   logic [127:0] rk_mem [16];
   int           model_nr;

   assign aes_if.round_key = rk_mem[aes_if.round];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-matrix AES) ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
   endfunction

   task automatic load_key(input logic [255:0] key, input bit k256);
      logic [31:0] kw [60];
      logic [31:0] temp;
      logic [7:0]  rcon = 8'h01;
      int nk = k256 ? 8 : 4;
      model_nr = k256 ? 14 : 10;
      for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(model_nr+1); i++) begin
         temp = kw[i-1];
         if (i % nk == 0) begin
            temp = subw({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
            rcon = gf_mul(rcon, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            temp = subw(temp);
         end
         kw[i] = kw[i-nk] ^ temp;
      end
      for (int r = 0; r <= model_nr; r++)
         rk_mem[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
   endtask

   function automatic logic [127:0] ref_cipher(input logic [127:0] pt);
      logic [7:0]   st [16];
      logic [7:0]   t [16];
      logic [127:0] res;
      for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ rk_mem[0][127-8*k -: 8];
      for (int r = 1; r <= model_nr; r++) begin
         for (int k = 0; k < 16; k++) st[k] = sb_tab[st[k]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c+rr] = st[4*((c+rr)%4)+rr];
         for (int c = 0; c < 4; c++) begin
            if (r < model_nr) begin
               st[4*c+0] = gf_mul(t[4*c], 8'h02) ^ gf_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               st[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 8'h02) ^ gf_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
               st[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 8'h02) ^ gf_mul(t[4*c+3], 8'h03);
               st[4*c+3] = gf_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 8'h02);
            end else begin
               for (int rr = 0; rr < 4; rr++) st[4*c+rr] = t[4*c+rr];
            end
         end
         for (int k = 0; k < 16; k++) st[k] ^= rk_mem[r][127-8*k -: 8];
      end
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
      return res;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit   prev_rdy = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_rdy = aes_if.ready;
         end else begin
            if (aes_if.ready && !prev_rdy) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 128'(aes_if.ready), 128'(0));
               end else begin
                  e = sb_q.pop_front();
                  check({e.name, "_ct"}, aes_if.new_block, e.ct);
                  check({e.name, "_latency"}, 128'(cyc - e.start + 1), 128'(e.lat));
               end
            end
            prev_rdy = aes_if.ready;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [127:0] pt, input bit k256, input logic [127:0] exp_ct,
                        input string name, input bit track);
      exp_t e;
      aes_if.block  = pt;
      aes_if.keylen = k256;
      aes_if.next   = 1'b1;
      if (track) begin
         e.ct = exp_ct; e.start = cyc + 1; e.lat = k256 ? LAT256 : LAT128; e.name = name;
         sb_q.push_back(e);
      end
      @(negedge clk);
      aes_if.next = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check({name, "_timeout"}, 128'(sb_q.size()), 128'(0));
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      logic [63:0]  seq_obs, seq_exp;
      logic [3:0]   last_round;
      int           seq_n, n, s1;
      logic [127:0] pt2, exp2, pt, ct;
      logic [255:0] key;
      bit           k256;

      build_sbox();
      for (int i = 0; i < 16; i++) rk_mem[i] = 128'h0;
      aes_if.next   = 1'b0;
      aes_if.keylen = 1'b0;
      aes_if.block  = 128'h0;
      reset_n       = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", 128'(aes_if.ready), 128'(1));
      check("reset_round", 128'(aes_if.round), 128'(0));
      check("reset_new_block", aes_if.new_block, 128'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // FIPS-197 C.1
      load_key(C1_KEY, 1'b0);
      issue(C_PT, 1'b0, C1_CT, "c1", 1'b1);
      wait_done("c1");
      repeat (5) @(negedge clk);
      check("idle_hold", aes_if.new_block, C1_CT);

      // FIPS-197 C.3 with round sequence capture
      load_key(C3_KEY, 1'b1);
      issue(C_PT, 1'b1, C3_CT, "c3", 1'b1);
      seq_obs = 64'h0; seq_n = 0; last_round = 4'h0; n = 0;
      while (n < 300) begin
         if (seq_n == 0 || aes_if.round != last_round) begin
            seq_obs = {seq_obs[59:0], aes_if.round};
            last_round = aes_if.round;
            seq_n++;
         end
         if (aes_if.ready) break;
         @(negedge clk);
         n++;
      end
      seq_exp = 64'h0;
      for (int i = 0; i <= 14; i++) seq_exp = {seq_exp[59:0], 4'(i)};
      check("c3_round_seq", {seq_obs, 64'(seq_n)}, {seq_exp, 64'd15});
      wait_done("c3");
      check("c3_round_hold", 128'(aes_if.round), 128'd14);

      // SP800-38A with next/keylen/block disturbed while busy
      load_key(SP_KEY, 1'b0);
      issue(SP_PT, 1'b0, SP_CT, "sp800_busy", 1'b1);
      repeat (4) @(negedge clk);
      aes_if.next = 1'b1; aes_if.keylen = 1'b1; aes_if.block = {4{$urandom}};
      @(negedge clk);
      aes_if.next = 1'b0;
      repeat (4) @(negedge clk);
      aes_if.keylen = 1'b0; aes_if.block = {4{$urandom}};
      @(negedge clk);
      aes_if.next = 1'b1;
      @(negedge clk);
      aes_if.next = 1'b0;
      wait_done("sp800_busy");

      // Reset in round 5, then C.1 again
      load_key(C1_KEY, 1'b0);
      issue(C_PT, 1'b0, C1_CT, "aborted", 1'b0);
      n = 0;
      while (aes_if.round != 4'd5 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("reach_round5", 128'(aes_if.round), 128'd5);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_ready", 128'(aes_if.ready), 128'(1));
      check("async_reset_round", 128'(aes_if.round), 128'(0));
      check("async_reset_new_block", aes_if.new_block, 128'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(C_PT, 1'b0, C1_CT, "c1_after_reset", 1'b1);
      wait_done("c1_after_reset");

      // Back-to-back with next held high
      pt2  = {$urandom, $urandom, $urandom, $urandom};
      exp2 = ref_cipher(pt2);
      aes_if.block  = C_PT;
      aes_if.keylen = 1'b0;
      aes_if.next   = 1'b1;
      s1 = cyc + 1;
      sb_q.push_back('{ct: C1_CT, start: s1, lat: LAT128, name: "b2b_first"});
      sb_q.push_back('{ct: exp2, start: s1 + LAT128, lat: LAT128, name: "b2b_second"});
      repeat (2) @(negedge clk);
      aes_if.block = pt2;
      n = 0;
      while (cyc < s1 + LAT128 && n < 300) begin
         @(negedge clk);
         n++;
      end
      aes_if.next = 1'b0;
      wait_done("b2b");

      // Randomized operations against the reference model
      for (int t = 0; t < 6; t++) begin
         k256 = 1'($urandom_range(0, 1));
         key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt   = {$urandom, $urandom, $urandom, $urandom};
         load_key(key, k256);
         ct = ref_cipher(pt);
         issue(pt, k256, ct, $sformatf("rand%0d", t), 1'b1);
         wait_done($sformatf("rand%0d", t));
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
